// File: rtl/char_ram_writer_pkg.sv
// Shared constants and FSM state type for the character RAM write controller.
package char_ram_pkg;

    localparam int ADDR_W = 10;    // {row[4:0], col[4:0]}
    localparam int DATA_W = 8;
    localparam int CELLS  = 1024;  // 32 x 32 character cells

    // IDLE drains the request FIFO, CLEAR runs the whole-screen fill sweep.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/char_ram_writer_if.sv
// Cell-write request channel into the character RAM writer.
// Handshake: a transfer happens on every clock edge where req_valid and
// req_ready are both 1. While req_valid is 1 and req_ready is 0, the master
// holds req_addr and req_data stable. req_ready does not depend on req_valid.
interface char_ram_writer_if #(
    parameter int ADDR_W = char_ram_pkg::ADDR_W,
    parameter int DATA_W = char_ram_pkg::DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/char_ram_writer_sync_fifo.sv
// Small synchronous FIFO holding pending {addr, data} cell writes.
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] storage [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Guard against pushing into a full or popping an empty FIFO.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = storage[rd_ptr_q];

    // Pointer and occupancy update; simultaneous push and pop keeps the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/char_ram_writer.sv
// Write-side controller for the 32x32 character RAM: buffers cell writes,
// runs the fill sweep, and only drives the RAM port while the display blanks.
module char_ram_writer #(
    parameter int ADDR_W     = char_ram_pkg::ADDR_W,
    parameter int DATA_W     = char_ram_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    char_ram_writer_if.slave     req,
    input  logic                 clr_start,
    input  logic [DATA_W-1:0]    clr_value,
    output logic                 busy,
    output logic                 clr_done,
    input  logic                 display_on,
    input  logic [ADDR_W-1:0]    disp_addr,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [DATA_W-1:0]    ram_din,
    output logic                 ram_we,
    output char_ram_pkg::state_t dbg_state
);
    import char_ram_pkg::*;

    localparam int                ENTRY_W   = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic                done_q, done_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  fifo_head;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;

    assign req.req_ready = ~fifo_full;
    assign fifo_push     = req.req_valid & ~fifo_full;
    assign head_addr     = fifo_head[ENTRY_W-1:DATA_W];
    assign head_data     = fifo_head[DATA_W-1:0];

    // The display owns the RAM whenever display_on is high; writes wait for blanking.
    assign ram_we   = ~display_on & ((state_q == CLEAR) | ~fifo_empty);
    // The sweep takes priority, so the FIFO only drains in IDLE.
    assign fifo_pop = ram_we & (state_q == IDLE);

    assign busy      = (state_q == CLEAR) | ~fifo_empty;
    assign clr_done  = done_q;
    assign dbg_state = state_q;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({req.req_addr, req.req_data}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // RAM address/data mux: display read address, sweep counter, or FIFO head.
    always_comb begin
        ram_addr = head_addr;
        ram_din  = head_data;
        if (state_q == CLEAR) begin
            ram_addr = cnt_q;
            ram_din  = fill_q;
        end
        if (display_on) ram_addr = disp_addr;
    end

    // Next-state logic: start sweep on clr_start, step counter on each committed write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    fill_d  = clr_value;
                end
            end
            CLEAR: begin
                // clr_start is ignored here: a running sweep is never restarted.
                if (ram_we) begin
                    if (cnt_q == LAST_CELL) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, sweep counter, latched fill byte and done pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_char_ram_writer.sv
// Self-checking bench for char_ram_writer with a behavioural RAM and write log.
module tb_char_ram_writer;
    import char_ram_pkg::*;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int EW = AW + DW;

    logic          clk;
    logic          reset;
    logic          clr_start;
    logic [DW-1:0] clr_value;
    logic          busy;
    logic          clr_done;
    logic          display_on;
    logic [AW-1:0] disp_addr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    state_t        dbg_state;

    char_ram_writer_if #(.ADDR_W(AW), .DATA_W(DW)) req_if ();

    char_ram_writer #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req_if.slave),
        .clr_start  (clr_start),
        .clr_value  (clr_value),
        .busy       (busy),
        .clr_done   (clr_done),
        .display_on (display_on),
        .disp_addr  (disp_addr),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #20 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ram_mem [1024];   // the RAM the DUT drives
    logic [DW-1:0] ref_mem [1024];   // expected RAM contents
    logic [EW-1:0] wr_log [$];       // every committed write, in order
    logic [EW-1:0] exp_q [$];        // expected writes for the current scenario
    int            we_while_disp = 0;
    int            addr_mux_err  = 0;
    int            done_cnt      = 0;
    logic [DW-1:0] last_fill;

    // Behavioural RAM plus write log; records only, never judges.
    always @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_addr] = ram_din;
            wr_log.push_back({ram_addr, ram_din});
            if (display_on) we_while_disp++;
        end
        if (display_on && ram_addr !== disp_addr) addr_mux_err++;
        if (clr_done) done_cnt++;
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        display_on = 1'b0;
        req_if.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ram_we !== 1'b0)      begin errors++; $display("FAIL reset_we got=%b exp=0", ram_we); end
        checks++; if (req_if.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_if.req_ready); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (clr_done !== 1'b0)    begin errors++; $display("FAIL reset_done got=%b exp=0", clr_done); end
        checks++; if (dbg_state !== IDLE)   begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
        display_on = 1'b1;
        disp_addr = AW'($urandom_range(0, 1023));
        #1;
        checks++; if (ram_addr !== disp_addr) begin errors++; $display("FAIL reset_addr_mux got=%h exp=%h", ram_addr, disp_addr); end
        @(negedge clk);
        display_on = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        display_on = 1'b0;
        req_if.req_valid = 1'b1;
        req_if.req_addr = 10'h021;
        req_if.req_data = 8'h05;
        @(negedge clk);
        req_if.req_valid = 1'b0;
        #1;
        checks++; if (ram_we !== 1'b1)     begin errors++; $display("FAIL single_we got=%b exp=1", ram_we); end
        checks++; if (ram_addr !== 10'h021) begin errors++; $display("FAIL single_addr got=%h exp=021", ram_addr); end
        checks++; if (ram_din !== 8'h05)   begin errors++; $display("FAIL single_din got=%h exp=05", ram_din); end
        checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL single_busy_on got=%b exp=1", busy); end
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL single_busy_off got=%b exp=0", busy); end
        checks++; if (ram_we !== 1'b0)     begin errors++; $display("FAIL single_we_off got=%b exp=0", ram_we); end
        checks++; if (ram_mem[10'h021] !== 8'h05) begin errors++; $display("FAIL single_readback got=%h exp=05", ram_mem[10'h021]); end
        ref_mem[10'h021] = 8'h05;
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] e;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            display_on = 1'b1;
            disp_addr = AW'($urandom_range(0, 1023));
            req_if.req_valid = 1'b1;
            req_if.req_addr = AW'($urandom_range(0, 1023));
            req_if.req_data = DW'($urandom_range(0, 255));
            #1;
            checks++; if (req_if.req_ready !== (i < 4)) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=%b", i, req_if.req_ready, (i < 4)); end
            checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL bp_we_held[%0d] got=%b exp=0", i, ram_we); end
            checks++; if (ram_addr !== disp_addr) begin errors++; $display("FAIL bp_addr_mux[%0d] got=%h exp=%h", i, ram_addr, disp_addr); end
            if (i < 4) exp_q.push_back({req_if.req_addr, req_if.req_data});
        end
        @(negedge clk);
        req_if.req_valid = 1'b0;
        display_on = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            e = exp_q.pop_front();
            checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL bp_drain_we[%0d] got=%b exp=1", k, ram_we); end
            checks++; if ({ram_addr, ram_din} !== e) begin errors++; $display("FAIL bp_drain_word[%0d] got=%h exp=%h", k, {ram_addr, ram_din}, e); end
            ref_mem[e[EW-1:DW]] = e[DW-1:0];
            @(negedge clk);
        end
        #1;
        checks++; if (ram_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_drained got_we=%b got_busy=%b exp=0/0", ram_we, busy); end
    endtask

    task automatic test_random_traffic();
        logic [EW-1:0] mq [$];
        logic          exp_ready;
        logic          exp_we;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            display_on = ($urandom_range(0, 3) == 0);
            disp_addr = AW'($urandom_range(0, 1023));
            req_if.req_valid = ($urandom_range(0, 1) == 1);
            req_if.req_addr = AW'($urandom_range(0, 1023));
            req_if.req_data = DW'($urandom_range(0, 255));
            exp_ready = (mq.size() < 4);
            exp_we = !display_on && (mq.size() > 0);
            #1;
            checks++; if (req_if.req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, req_if.req_ready, exp_ready); end
            checks++; if (ram_we !== exp_we) begin errors++; $display("FAIL rnd_we[%0d] got=%b exp=%b", c, ram_we, exp_we); end
            checks++; if (busy !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_busy[%0d] got=%b exp=%b", c, busy, (mq.size() != 0)); end
            if (exp_we) begin
                checks++; if ({ram_addr, ram_din} !== mq[0]) begin errors++; $display("FAIL rnd_word[%0d] got=%h exp=%h", c, {ram_addr, ram_din}, mq[0]); end
                ref_mem[mq[0][EW-1:DW]] = mq[0][DW-1:0];
                void'(mq.pop_front());
            end else if (display_on) begin
                checks++; if (ram_addr !== disp_addr) begin errors++; $display("FAIL rnd_addr_mux[%0d] got=%h exp=%h", c, ram_addr, disp_addr); end
            end
            if (req_if.req_valid && exp_ready) mq.push_back({req_if.req_addr, req_if.req_data});
        end
        @(negedge clk);
        req_if.req_valid = 1'b0;
        display_on = 1'b0;
        while (mq.size() > 0) begin
            #1;
            checks++; if ({ram_we, ram_addr, ram_din} !== {1'b1, mq[0]}) begin errors++; $display("FAIL rnd_drain got=%h exp=%h", {ram_we, ram_addr, ram_din}, {1'b1, mq[0]}); end
            ref_mem[mq[0][EW-1:DW]] = mq[0][DW-1:0];
            void'(mq.pop_front());
            @(negedge clk);
        end
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_clear_with_pending();
        int base_done;
        int cyc;
        int bad;
        bit seen;
        @(negedge clk);
        display_on = 1'b1;
        req_if.req_valid = 1'b1;
        req_if.req_addr = 10'h3FF;
        req_if.req_data = 8'h07;
        clr_start = 1'b1;
        clr_value = 8'h00;
        @(negedge clk);
        req_if.req_valid = 1'b0;
        clr_start = 1'b0;
        display_on = 1'b0;
        wr_log.delete();
        base_done = done_cnt;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 1100) begin
            #1;
            if (clr_done === 1'b1) seen = 1'b1;
            else begin @(negedge clk); cyc++; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL clr_timeout got=no_done exp=done_within_1100"); end
        checks++; if (wr_log.size() != 1024) begin errors++; $display("FAIL clr_sweep_count got=%0d exp=1024", wr_log.size()); end
        checks++; if ({ram_we, ram_addr, ram_din} !== {1'b1, 10'h3FF, 8'h07}) begin errors++; $display("FAIL clr_fifo_after got=%h exp=%h", {ram_we, ram_addr, ram_din}, {1'b1, 10'h3FF, 8'h07}); end
        @(negedge clk);
        #1;
        exp_q.delete();
        for (int a = 0; a < 1024; a++) exp_q.push_back({AW'(a), 8'h00});
        exp_q.push_back({10'h3FF, 8'h07});
        bad = 0;
        if (wr_log.size() != exp_q.size()) bad++;
        else for (int i = 0; i < exp_q.size(); i++) if (wr_log[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL clr_write_order got_bad=%0d exp=0 (log size %0d)", bad, wr_log.size()); end
        for (int a = 0; a < 1024; a++) ref_mem[a] = 8'h00;
        ref_mem[10'h3FF] = 8'h07;
        bad = 0;
        for (int a = 0; a < 1024; a++) if (ram_mem[a] !== ref_mem[a]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL clr_ram_image got_bad_cells=%0d exp=0", bad); end
        checks++; if (done_cnt - base_done != 1) begin errors++; $display("FAIL clr_done_pulses got=%0d exp=1", done_cnt - base_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_toggle_sweep_restart();
        logic [DW-1:0] v;
        int base_done;
        int base_wd;
        int base_mux;
        int cyc;
        int bad;
        bit seen;
        bit restarted;
        v = DW'($urandom_range(1, 255));
        @(negedge clk);
        wr_log.delete();
        base_done = done_cnt;
        base_wd = we_while_disp;
        base_mux = addr_mux_err;
        display_on = 1'b0;
        clr_start = 1'b1;
        clr_value = v;
        seen = 1'b0;
        restarted = 1'b0;
        cyc = 0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            clr_start = 1'b0;
            display_on = ((cyc / 7) % 2 == 1);
            disp_addr = AW'($urandom_range(0, 1023));
            if (!restarted && wr_log.size() >= 500) begin
                clr_start = 1'b1;
                clr_value = ~v;
                restarted = 1'b1;
            end
            #1;
            if (clr_done === 1'b1) seen = 1'b1;
        end
        @(negedge clk);
        clr_start = 1'b0;
        display_on = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (!seen) begin errors++; $display("FAIL tog_timeout got=no_done exp=done_within_3000"); end
        checks++; if (wr_log.size() != 1024) begin errors++; $display("FAIL tog_write_count got=%0d exp=1024", wr_log.size()); end
        bad = 0;
        for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] !== {AW'(i), v}) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL tog_write_order got_bad=%0d exp=0", bad); end
        checks++; if (we_while_disp != base_wd) begin errors++; $display("FAIL tog_we_during_display got=%0d exp=0", we_while_disp - base_wd); end
        checks++; if (addr_mux_err != base_mux) begin errors++; $display("FAIL tog_addr_mux got=%0d exp=0", addr_mux_err - base_mux); end
        checks++; if (done_cnt - base_done != 1) begin errors++; $display("FAIL tog_done_pulses got=%0d exp=1", done_cnt - base_done); end
        checks++; if (busy !== 1'b0 || dbg_state !== IDLE) begin errors++; $display("FAIL tog_idle got_busy=%b got_state=%0d exp=0/0", busy, dbg_state); end
        for (int a = 0; a < 1024; a++) ref_mem[a] = v;
        last_fill = v;
    endtask

    task automatic test_reset_mid_sweep();
        logic [DW-1:0] w;
        int base_done;
        int cyc;
        int bad;
        w = last_fill ^ 8'h5A;
        @(negedge clk);
        wr_log.delete();
        base_done = done_cnt;
        display_on = 1'b0;
        clr_start = 1'b1;
        clr_value = w;
        cyc = 0;
        @(negedge clk);
        clr_start = 1'b0;
        while (wr_log.size() < 300 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (wr_log.size() != 300) begin errors++; $display("FAIL rst_sweep_progress got=%0d exp=300", wr_log.size()); end
        reset = 1'b1;
        #1;
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, IDLE); end
        checks++; if ({busy, ram_we, clr_done, req_if.req_ready} !== 4'b0001) begin errors++; $display("FAIL rst_outputs got=%b exp=0001", {busy, ram_we, clr_done, req_if.req_ready}); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (done_cnt != base_done) begin errors++; $display("FAIL rst_no_done got=%0d exp=0", done_cnt - base_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_after got=%b exp=0", busy); end
        for (int a = 0; a < 300; a++) ref_mem[a] = w;
        bad = 0;
        for (int a = 0; a < 1024; a++) if (ram_mem[a] !== ref_mem[a]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_ram_image got_bad_cells=%0d exp=0", bad); end
    endtask

    // ---------------- sequence ----------------
    initial begin
        for (int a = 0; a < 1024; a++) begin
            ram_mem[a] = '0;
            ref_mem[a] = '0;
        end
        reset = 1'b1;
        clr_start = 1'b0;
        clr_value = '0;
        display_on = 1'b0;
        disp_addr = '0;
        req_if.req_valid = 1'b0;
        req_if.req_addr = '0;
        req_if.req_data = '0;
        last_fill = '0;

        test_reset();
        test_single_write();
        test_backpressure();
        test_random_traffic();
        test_clear_with_pending();
        test_toggle_sweep_restart();
        test_reset_mid_sweep();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
